// File: rtl/seg7_result_driver_if.sv
// Signal bundle between the inference/argmax stage and the 7-segment pin driver.
// The master side drives start/done/class_idx. The slave side drives the display pins.
interface seg7_result_driver_if #(
    parameter int CLASS_W = 4
) ();
    logic               start;
    logic               done;
    logic [CLASS_W-1:0] class_idx;
    logic               CA, CB, CC, CD, CE, CF, CG;
    logic [3:0]         AN;
    logic               busy;

    modport master (
        output start, done, class_idx,
        input  CA, CB, CC, CD, CE, CF, CG, AN, busy
    );

    modport slave (
        input  start, done, class_idx,
        output CA, CB, CC, CD, CE, CF, CG, AN, busy
    );
endinterface

// File: rtl/seg7_result_driver.sv
// Tracks one inference (start -> done), latches the predicted class and
// scans it onto a 4-digit common-anode display: blank / dashes / class digit.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_BLANK | after reset, nothing shown yet
// ST_BUSY  | inference running, dashes on every digit
// ST_SHOW  | result latched, class on digit 0, others blank
module seg7_result_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int CLASS_W     = 4
) (
    input logic                 clk,
    input logic                 rst,
    seg7_result_driver_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_E     = 7'b0110000;

    typedef enum logic [1:0] {ST_BLANK, ST_BUSY, ST_SHOW} state_t;

    state_t             state_q, state_d;
    logic               start_q, done_q;
    logic               start_rise, done_rise;
    logic [CLASS_W-1:0] class_q, class_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [1:0]         scan_q, scan_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               busy_q, busy_d;
    logic               wrap;

    function automatic logic [6:0] encode(input logic [CLASS_W-1:0] c);
        logic [6:0] s;
        case (int'(c))
            0:       s = 7'b0000001;
            1:       s = 7'b1001111;
            2:       s = 7'b0010010;
            3:       s = 7'b0000110;
            4:       s = 7'b1001100;
            5:       s = 7'b0100100;
            6:       s = 7'b0100000;
            7:       s = 7'b0001111;
            8:       s = 7'b0000000;
            9:       s = 7'b0000100;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

    assign start_rise = bus.start & ~start_q;
    assign done_rise  = bus.done  & ~done_q;

    // Prescaler/scan: AN is registered from the pre-wrap scan index, so it
    // moves one cycle after the wrap.
    assign wrap    = (presc_q == PRESC_MAX);
    assign presc_d = wrap ? '0 : presc_q + 1'b1;
    assign scan_d  = wrap ? scan_q + 2'd1 : scan_q;
    assign an_d    = ~(4'b0001 << scan_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            class_q <= '0;
            presc_q <= '0;
            scan_q  <= 2'd0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'b1111;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            done_q  <= bus.done;
            class_q <= class_d;
            presc_q <= presc_d;
            scan_q  <= scan_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            busy_q  <= busy_d;
        end
    end

    // A start rise wins over a simultaneous done rise unless already busy.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        unique case (state_q)
            ST_BLANK: if (start_rise) state_d = ST_BUSY;
            ST_BUSY: begin
                if (done_rise) begin
                    state_d = ST_SHOW;
                    class_d = bus.class_idx;
                end
            end
            ST_SHOW:  if (start_rise) state_d = ST_BUSY;
            default:  state_d = ST_BLANK;
        endcase
    end

    always_comb begin
        seg_d  = SEG_BLANK;
        busy_d = (state_d == ST_BUSY);
        unique case (state_q)
            ST_BUSY:  seg_d = SEG_DASH;
            ST_SHOW:  seg_d = (scan_q == 2'd0) ? encode(class_q) : SEG_BLANK;
            default:  seg_d = SEG_BLANK;
        endcase
    end

    assign {bus.CA, bus.CB, bus.CC, bus.CD, bus.CE, bus.CF, bus.CG} = seg_q;
    assign bus.AN   = an_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_seg7_result_driver.sv
// Scoreboard bench: a cycle-counting reference model pushes the expected pin
// state per clock edge; a monitor pops and compares just after each edge.
module tb_seg7_result_driver;
    localparam int DIV = 4;
    localparam int CW  = 4;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b1111110;

    localparam int M_BLANK = 0;
    localparam int M_BUSY  = 1;
    localparam int M_SHOW  = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_result_driver_if #(.CLASS_W(CW)) bus ();

    seg7_result_driver #(.REFRESH_DIV(DIV), .CLASS_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] digit_tab [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    function automatic logic [6:0] glyph(input int c);
        if (c <= 9) return digit_tab[c];
        return 7'b0110000;
    endfunction

    // Reference model: digit position is derived from edges since reset.
    int m_state, m_class, m_cyc, m_dig;
    bit m_ps, m_pd, m_sr, m_dr;

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            e       = '{seg: BLANK, an: 4'b1111, busy: 1'b0};
            m_state = M_BLANK;
            m_class = 0;
            m_cyc   = 0;
            m_ps    = 1'b0;
            m_pd    = 1'b0;
        end else begin
            m_dig  = (m_cyc / DIV) % 4;
            e.an   = ~(4'b0001 << m_dig);
            if (m_state == M_BUSY)                    e.seg = DASH;
            else if (m_state == M_SHOW && m_dig == 0) e.seg = glyph(m_class);
            else                                      e.seg = BLANK;
            m_sr = bus.start && !m_ps;
            m_dr = bus.done && !m_pd;
            if (m_sr && m_state != M_BUSY) begin
                m_state = M_BUSY;
            end else if (m_dr && m_state == M_BUSY) begin
                m_state = M_SHOW;
                m_class = int'(bus.class_idx);
            end
            e.busy = (m_state == M_BUSY);
            m_ps   = bus.start;
            m_pd   = bus.done;
            m_cyc++;
        end
        exp_q.push_back(e);
    end

    int printed = 0;
    task automatic report(input string name, input logic [6:0] got, input logic [6:0] want);
        errors++;
        if (printed < 40) begin
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, want);
            printed++;
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic [6:0] seg_got;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            report("scoreboard_empty", 7'd0, 7'd1);
        end else begin
            e = exp_q.pop_front();
            seg_got = {bus.CA, bus.CB, bus.CC, bus.CD, bus.CE, bus.CF, bus.CG};
            if (seg_got !== e.seg) report("segments", seg_got, e.seg);
            checks++;
            if (bus.AN !== e.an) report("anodes", {3'b0, bus.AN}, {3'b0, e.an});
            checks++;
            if (bus.busy !== e.busy) report("busy", {6'b0, bus.busy}, {6'b0, e.busy});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.done = 1'b0;
        bus.class_idx = '0;
        tick(3);
        rst = 1'b0;
        tick(20);

        // start, then done with class 7 twenty cycles later
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
        tick(19);
        bus.done = 1'b1; bus.class_idx = 4'd7; tick(1); bus.done = 1'b0;
        tick(20);

        // class 12 shows E
        bus.start = 1'b1; tick(1); bus.start = 1'b0; tick(5);
        bus.done = 1'b1; bus.class_idx = 4'd12; tick(1); bus.done = 1'b0;
        tick(20);

        // simultaneous start/done in SHOW: start wins, no relatch
        bus.start = 1'b1; bus.done = 1'b1; bus.class_idx = 4'd5; tick(1);
        bus.start = 1'b0; bus.done = 1'b0; tick(10);
        bus.done = 1'b1; bus.class_idx = 4'd3; tick(1); bus.done = 1'b0;
        tick(20);

        // done in BLANK ignored; reset mid-scan while showing
        rst = 1'b1; tick(1); rst = 1'b0; tick(3);
        bus.done = 1'b1; bus.class_idx = 4'd4; tick(1); bus.done = 1'b0; tick(10);
        bus.start = 1'b1; tick(1); bus.start = 1'b0; tick(3);
        bus.done = 1'b1; bus.class_idx = 4'd9; tick(1); bus.done = 1'b0; tick(6);
        rst = 1'b1; tick(1); rst = 1'b0; tick(10);

        // held levels give exactly one entry / one latch
        bus.start = 1'b1; tick(50); bus.start = 1'b0; tick(2);
        bus.done = 1'b1; bus.class_idx = 4'd2; tick(1);
        bus.class_idx = 4'd8; tick(10); bus.done = 1'b0; tick(20);

        // randomized traffic
        repeat (3000) begin
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 7) == 0) bus.start = ~bus.start;
            if ($urandom_range(0, 5) == 0) bus.done = ~bus.done;
            bus.class_idx = CW'($urandom_range(0, 15));
            tick(1);
        end
        rst = 1'b0;
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
